// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared types, constants and helpers for the AES/PRNG scheduler
// Purpose : state encoding, seed width, counter-width helper and the auto-reseed build switch.
// Build   : AES_SCHED_AUTORESEED_EN (undefined by default) enables the forced reseed after
//           RESEED_PERIOD encryptions.
package aes_sched_pkg;

  localparam int SEED_W = 80;

`ifdef AES_SCHED_AUTORESEED_EN
  localparam bit AUTORESEED_EN = 1'b1;
`else
  localparam bit AUTORESEED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_NOSEED,
    ST_RESEED,
    ST_WAITP,
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_HOLD
  } sched_state_e;

  // Counter must be able to hold the value RESEED_PERIOD itself.
  function automatic int sched_cnt_w(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/aes_sched_enc_cnt.sv
// rtl/aes_sched_enc_cnt.sv - saturating encryption counter with terminal-count compare
// Purpose : counts encryptions since the last seed; saturates at all-ones.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           clr_i        - clear to zero (wins over inc_i)
//           inc_i        - increment by one unless saturated
//           cnt_o        - current count
//           tc_o         - count equals PERIOD
module aes_sched_enc_cnt
  import aes_sched_pkg::*;
#(
  parameter int PERIOD = 1024,
  parameter int CNT_W  = sched_cnt_w(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CNT_TC);

endmodule

// File: rtl/aes_prng_scheduler.sv
// rtl/aes_prng_scheduler.sv - handshake sequencer between host, masked AES core and PRNG
// Purpose : seeds the PRNG, waits for valid randomness, launches one encryption at a time,
//           keeps PRNG output flowing during it and holds each result until the host takes it.
// Build   : AES_SCHED_AUTORESEED_EN - when defined, a result handed over with
//           enc_count == RESEED_PERIOD sends the scheduler back to NOSEED.
// Ports   : clk, rst                          - clock, synchronous active-high reset
//           in_valid/in_ready                 - host encryption request
//           out_valid/out_ready, ct_capture   - result hand-off and capture strobe
//           seed_in/seed_valid/seed_ready     - fresh seed from host; need_seed when blocked
//           prng_seed, prng_start_reseed,
//           prng_out_ready/valid, prng_busy   - PRNG control
//           aes_valid_in/aes_ready,
//           aes_cipher_valid                  - AES core control
//           enc_count, rnd_err                - status
module aes_prng_scheduler
  import aes_sched_pkg::*;
#(
  parameter int RESEED_PERIOD = 1024,
  parameter int CNT_W         = sched_cnt_w(RESEED_PERIOD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ct_capture,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic              need_seed,
  output logic [SEED_W-1:0] prng_seed,
  output logic              prng_start_reseed,
  output logic              prng_out_ready,
  input  logic              prng_out_valid,
  input  logic              prng_busy,
  output logic              aes_valid_in,
  input  logic              aes_ready,
  input  logic              aes_cipher_valid,
  output logic [CNT_W-1:0]  enc_count,
  output logic              rnd_err
);

  sched_state_e state_q, state_d;

  logic              seed_acc;
  logic              cnt_inc;
  logic              cnt_tc;
  logic              in_core;

  logic              need_seed_q, need_seed_d;
  logic              reseed_q, reseed_d;
  logic              aes_valid_q, aes_valid_d;
  logic              prng_rdy_q, prng_rdy_d;
  logic              out_valid_q, out_valid_d;
  logic              ct_capture_q, ct_capture_d;
  logic              rnd_err_q, rnd_err_d;
  logic [SEED_W-1:0] prng_seed_q, prng_seed_d;

  // A seed offered in IDLE pre-empts a request in the same cycle.
  assign seed_acc   = seed_valid && ((state_q == ST_NOSEED) || (state_q == ST_IDLE));
  assign seed_ready = seed_acc;
  assign in_ready   = (state_q == ST_IDLE) && !seed_valid;
  assign cnt_inc    = (state_q == ST_LAUNCH) && aes_ready;
  assign in_core    = (state_q == ST_LAUNCH) || (state_q == ST_RUN);

  aes_sched_enc_cnt #(
    .PERIOD (RESEED_PERIOD),
    .CNT_W  (CNT_W)
  ) u_enc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (seed_acc),
    .inc_i (cnt_inc),
    .cnt_o (enc_count),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NOSEED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NOSEED: if (seed_valid) state_d = ST_RESEED;
      ST_RESEED: state_d = ST_WAITP;
      ST_WAITP:  if (!prng_busy && prng_out_valid) state_d = ST_IDLE;
      ST_IDLE: begin
        if (seed_valid) begin
          state_d = ST_RESEED;
        end else if (in_valid) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: if (aes_ready) state_d = ST_RUN;
      ST_RUN:    if (aes_cipher_valid) state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          state_d = (AUTORESEED_EN && cnt_tc) ? ST_NOSEED : ST_IDLE;
        end
      end
      default:   state_d = ST_NOSEED;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    need_seed_d  = (state_d == ST_NOSEED);
    reseed_d     = (state_d == ST_RESEED);
    aes_valid_d  = (state_d == ST_LAUNCH);
    prng_rdy_d   = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    out_valid_d  = (state_d == ST_HOLD);
    ct_capture_d = (state_q == ST_RUN) && aes_cipher_valid;
    rnd_err_d    = rnd_err_q || (in_core && !prng_out_valid);
    prng_seed_d  = seed_acc ? seed_in : prng_seed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      need_seed_q  <= 1'b1;
      reseed_q     <= 1'b0;
      aes_valid_q  <= 1'b0;
      prng_rdy_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ct_capture_q <= 1'b0;
      rnd_err_q    <= 1'b0;
      prng_seed_q  <= '0;
    end else begin
      need_seed_q  <= need_seed_d;
      reseed_q     <= reseed_d;
      aes_valid_q  <= aes_valid_d;
      prng_rdy_q   <= prng_rdy_d;
      out_valid_q  <= out_valid_d;
      ct_capture_q <= ct_capture_d;
      rnd_err_q    <= rnd_err_d;
      prng_seed_q  <= prng_seed_d;
    end
  end

  assign need_seed         = need_seed_q;
  assign prng_start_reseed = reseed_q;
  assign aes_valid_in      = aes_valid_q;
  assign prng_out_ready    = prng_rdy_q;
  assign out_valid         = out_valid_q;
  assign ct_capture        = ct_capture_q;
  assign rnd_err           = rnd_err_q;
  assign prng_seed         = prng_seed_q;

endmodule

// File: tb/tb_aes_prng_scheduler.sv
// tb/tb_aes_prng_scheduler.sv - self-checking bench for aes_prng_scheduler
module tb_aes_prng_scheduler;

  localparam int PERIOD = 2;
  localparam int CW     = 2;
  localparam logic [79:0] SEED_A = 80'h1234_5678_9ABC_DEF0_1357;
  localparam logic [79:0] SEED_B = 80'hA5A5_0F0F_3C3C_9696_C3C3;
  localparam logic [79:0] SEED_C = 80'h0BAD_F00D_DEAD_BEEF_7777;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, ct_capture;
  logic [79:0]   seed_in;
  logic          seed_valid, seed_ready, need_seed;
  logic [79:0]   prng_seed;
  logic          prng_start_reseed, prng_out_ready, prng_out_valid, prng_busy;
  logic          aes_valid_in, aes_ready, aes_cipher_valid;
  logic [CW-1:0] enc_count;
  logic          rnd_err;

  int            n_checks = 0;
  int            n_errors = 0;
  int            model_cnt = 0;
  int            sb[$];

  aes_prng_scheduler #(.RESEED_PERIOD(PERIOD)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .ct_capture        (ct_capture),
    .seed_in           (seed_in),
    .seed_valid        (seed_valid),
    .seed_ready        (seed_ready),
    .need_seed         (need_seed),
    .prng_seed         (prng_seed),
    .prng_start_reseed (prng_start_reseed),
    .prng_out_ready    (prng_out_ready),
    .prng_out_valid    (prng_out_valid),
    .prng_busy         (prng_busy),
    .aes_valid_in      (aes_valid_in),
    .aes_ready         (aes_ready),
    .aes_cipher_valid  (aes_cipher_valid),
    .enc_count         (enc_count),
    .rnd_err           (rnd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_need_seed"}, need_seed, 1);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_ct_capture"}, ct_capture, 0);
    check({pfx, "_seed_ready"}, seed_ready, 0);
    check({pfx, "_prng_seed"}, prng_seed, 0);
    check({pfx, "_reseed"}, prng_start_reseed, 0);
    check({pfx, "_prng_out_ready"}, prng_out_ready, 0);
    check({pfx, "_aes_valid_in"}, aes_valid_in, 0);
    check({pfx, "_enc_count"}, enc_count, 0);
    check({pfx, "_rnd_err"}, rnd_err, 0);
  endtask

  // Offers a seed in NOSEED or IDLE and checks the one-cycle reseed pulse.
  task automatic give_seed(input string tag, input logic [79:0] s);
    seed_in    = s;
    seed_valid = 1'b1;
    #1;
    check({tag, "_seed_ready"}, seed_ready, 1);
    check({tag, "_in_ready_blocked"}, in_ready, 0);
    tick();
    seed_valid = 1'b0;
    model_cnt  = 0;
    check({tag, "_reseed_pulse"}, prng_start_reseed, 1);
    check({tag, "_prng_seed"}, prng_seed, s);
    check({tag, "_need_seed"}, need_seed, 0);
    check({tag, "_cnt_clear"}, enc_count, 0);
    check({tag, "_no_launch"}, aes_valid_in, 0);
    tick();
    check({tag, "_reseed_once"}, prng_start_reseed, 0);
  endtask

  // Raises in_valid, waits (bounded) for in_ready, completes the handshake and
  // pushes the enc_count the result should carry.
  task automatic request(input string tag);
    int n = 0;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_req_wait"}, (n < 50), 1);
    tick();
    in_valid  = 1'b0;
    model_cnt = (model_cnt == (1 << CW) - 1) ? model_cnt : model_cnt + 1;
    sb.push_back(model_cnt);
    check({tag, "_aes_valid_in"}, aes_valid_in, 1);
    check({tag, "_prng_rdy_launch"}, prng_out_ready, 1);
  endtask

  // Plays the AES core from LAUNCH to the host taking the result.
  task automatic complete(input string tag, input int delay, input int hold, input bit glitch);
    int exp_cnt;
    tick();
    check({tag, "_launch_done"}, aes_valid_in, 0);
    check({tag, "_prng_rdy_run"}, prng_out_ready, 1);
    if (glitch) begin
      prng_out_valid = 1'b0;
      tick();
      prng_out_valid = 1'b1;
      check({tag, "_rnd_err_set"}, rnd_err, 1);
    end
    repeat (delay) tick();
    aes_cipher_valid = 1'b1;
    tick();
    aes_cipher_valid = 1'b0;
    check({tag, "_ct_capture"}, ct_capture, 1);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_prng_rdy_hold"}, prng_out_ready, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp_cnt = sb.pop_front();
      check({tag, "_enc_count"}, enc_count, exp_cnt);
    end
    tick();
    check({tag, "_ct_capture_pulse"}, ct_capture, 0);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_out_valid_held"}, out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_no_in_ready_in_hold"}, in_ready, 0);
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    seed_in = '0;
    seed_valid = 1'b0;
    prng_out_valid = 1'b0;
    prng_busy = 1'b1;
    aes_ready = 1'b1;
    aes_cipher_valid = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;

    give_seed("seed_a", SEED_A);

    // Request while the PRNG is still busy: nothing may launch.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_no_launch", aes_valid_in, 0);
      check("busy_no_in_ready", in_ready, 0);
    end
    prng_busy = 1'b0;
    prng_out_valid = 1'b1;
    request("enc1");
    complete("enc1", 2, 5, 1'b0);
    check("rnd_err_clean", rnd_err, 0);

    request("enc2");
    complete("enc2", 1, 1, 1'b1);
    check("enc2_count", enc_count, 2);

`ifdef AES_SCHED_AUTORESEED_EN
    check("auto_need_seed", need_seed, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("auto_blocked_in_ready", in_ready, 0);
      check("auto_blocked_need_seed", need_seed, 1);
    end
    give_seed("seed_b", SEED_B);
    request("enc3");
    complete("enc3", 0, 0, 1'b0);
`else
    check("noauto_need_seed", need_seed, 0);
    request("enc3");
    complete("enc3", 0, 0, 1'b0);
    request("enc4");
    complete("enc4", 3, 2, 1'b0);
    check("sat_count", enc_count, 3);
`endif
    check("rnd_err_sticky", rnd_err, 1);

    // Seed and request together in IDLE: reseed wins, request follows WAITP.
    in_valid = 1'b1;
    give_seed("seed_c", SEED_C);
    request("enc5");
    complete("enc5", 0, 0, 1'b0);
    check("rnd_err_still", rnd_err, 1);

    // Reset while the core is running.
    request("enc6");
    tick();
    check("rst_run_state", prng_out_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    model_cnt = 0;
    check_reset_outputs("rst_mid");
    aes_cipher_valid = 1'b1;
    tick();
    aes_cipher_valid = 1'b0;
    check("late_cipher_ct", ct_capture, 0);
    check("late_cipher_out", out_valid, 0);
    check("late_cipher_need_seed", need_seed, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
